// File: rtl/adc_sample_avm_writer.sv
`default_nettype none
//============================================================================
// Module      : adc_sample_avm_writer
// Description : Avalon-MM write master that packs two ADC samples per
//               32-bit word and writes them to consecutive word addresses
//               of the on-chip sample memory. Supports a one-shot capture
//               or a circular buffer that restarts at the base address.
// Revision    : 1.0  initial release
//----------------------------------------------------------------------------
// Ports
//   clk             system clock (only clock)
//   reset_n         synchronous active-low reset
//   start           one-cycle pulse, begins a capture when idle
//   stop            level, ends the capture (flushes a half-filled word)
//   cfg_base        first word address (latched on start)
//   cfg_len         words per pass, 0..2^ADDR_W (latched on start)
//   cfg_circular    1 = restart at cfg_base after cfg_len words
//   smp_valid/smp_data/smp_ready   sample stream (valid/ready)
//   avm_*           Avalon-MM write master
//   busy            high whenever not idle
//   done            one-cycle pulse when a capture ends
//   wrapped         one-cycle pulse when the address returns to cfg_base
//   words_written   words written in the current pass
//============================================================================
module adc_sample_avm_writer #(
    parameter int ADDR_W   = 11,
    parameter int SAMPLE_W = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [ADDR_W:0]     cfg_len,
    input  logic                cfg_circular,
    input  logic                smp_valid,
    input  logic [SAMPLE_W-1:0] smp_data,
    output logic                smp_ready,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [3:0]          avm_byteenable,
    output logic [31:0]         avm_writedata,
    input  logic                avm_waitrequest,
    output logic                busy,
    output logic                done,
    output logic                wrapped,
    output logic [ADDR_W:0]     words_written
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LO   = 3'd1;
    localparam logic [2:0] c_HI   = 3'd2;
    localparam logic [2:0] c_WR   = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_WORDS_ONE = (ADDR_W+1)'(1);

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_len;
    logic                r_circ;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_words;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic                r_last;     // capture ends after the current write
    logic                r_wrapped;

    logic [15:0]         w_smp16;
    logic [ADDR_W:0]     w_words_inc;
    logic                w_pass_end;

    assign w_smp16     = 16'(smp_data);
    assign w_words_inc = r_words + c_WORDS_ONE;
    assign w_pass_end  = (w_words_inc == r_len);

    // In LO a stop takes priority over a sample, so the sample is not
    // handshaken that cycle.
    assign smp_ready      = ((r_state == c_LO) && !stop) || (r_state == c_HI);
    assign avm_write      = (r_state == c_WR);
    assign avm_chipselect = (r_state == c_WR);
    assign avm_address    = r_addr;
    assign avm_writedata  = r_wdata;
    assign avm_byteenable = r_be;
    assign busy           = (r_state != c_IDLE);
    assign done           = (r_state == c_DONE);
    assign wrapped        = r_wrapped;
    assign words_written  = r_words;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_base    <= '0;
            r_len     <= '0;
            r_circ    <= 1'b0;
            r_addr    <= '0;
            r_words   <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_last    <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_wrapped <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (cfg_len != '0) begin
                            r_base  <= cfg_base;
                            r_len   <= cfg_len;
                            r_circ  <= cfg_circular;
                            r_addr  <= cfg_base;
                            r_words <= '0;
                            r_last  <= 1'b0;
                            r_state <= c_LO;
                        end else begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_LO: begin
                    if (stop) begin
                        r_state <= c_DONE;
                    end else if (smp_valid) begin
                        r_wdata[15:0] <= w_smp16;
                        r_state       <= c_HI;
                    end
                end
                c_HI: begin
                    if (smp_valid) begin
                        // A stop arriving with the second sample still
                        // writes the full word, then ends the capture.
                        r_wdata[31:16] <= w_smp16;
                        r_be           <= 4'b1111;
                        r_last         <= stop;
                        r_state        <= c_WR;
                    end else if (stop) begin
                        r_wdata[31:16] <= 16'h0000;
                        r_be           <= 4'b0011;
                        r_last         <= 1'b1;
                        r_state        <= c_WR;
                    end
                end
                c_WR: begin
                    if (!avm_waitrequest) begin
                        if (w_pass_end && r_circ) begin
                            r_addr    <= r_base;
                            r_words   <= '0;
                            r_wrapped <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + c_ADDR_ONE;
                            r_words <= w_words_inc;
                        end
                        // A wrap coinciding with a stop still wraps; done
                        // then follows from the DONE state.
                        if (r_last || stop) begin
                            r_state <= c_DONE;
                        end else if (w_pass_end && !r_circ) begin
                            r_state <= c_DONE;
                        end else begin
                            r_state <= c_LO;
                        end
                    end else if (stop) begin
                        // Remember a stop seen while stalled.
                        r_last <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_avm_writer.sv
`timescale 1ns/1ps
module tb_adc_sample_avm_writer;

    localparam int AW = 11;
    localparam int SW = 12;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, start, stop, cfg_circular, smp_valid, avm_waitrequest;
    logic [AW-1:0] cfg_base;
    logic [AW:0]   cfg_len;
    logic [SW-1:0] smp_data;
    logic          smp_ready, avm_chipselect, avm_write, busy, done, wrapped;
    logic [AW-1:0] avm_address;
    logic [3:0]    avm_byteenable;
    logic [31:0]   avm_writedata;
    logic [AW:0]   words_written;

    adc_sample_avm_writer #(.ADDR_W(AW), .SAMPLE_W(SW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_circular(cfg_circular),
        .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .wrapped(wrapped), .words_written(words_written)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
    } wr_t;

    int            n_chk = 0;
    int            n_err = 0;
    wr_t           exp_q[$];
    logic [SW-1:0] smp_q[$];
    int            done_cnt = 0, wrap_cnt = 0, wr_cnt = 0, run = 0, max_run = 0;
    int            wr_mode = 0;   // 0: never stall, 2: random, 3: stall first write 3 cycles, 4: always stall
    int            stall_n = 0;
    bit            rand_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic          p_wr = 1'b0, p_wait = 1'b0;
    logic [AW-1:0] p_a = '0;
    logic [31:0]   p_d = '0;
    logic [3:0]    p_be = '0;
    always @(negedge clk) begin
        wr_t e;
        if (reset_n) begin
            check("cs_eq_write", 32'(avm_chipselect), 32'(avm_write));
            if (avm_write) check("ready_low_in_write", 32'(smp_ready), 32'd0);
            if (p_wr && p_wait) begin
                check("hold_write", 32'(avm_write), 32'd1);
                check("hold_addr", 32'(avm_address), 32'(p_a));
                check("hold_data", avm_writedata, p_d);
                check("hold_be", 32'(avm_byteenable), 32'(p_be));
            end
            if (avm_write) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (avm_write && !avm_waitrequest) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", avm_address, avm_writedata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(avm_address), 32'(e.a));
                    check("wr_data", avm_writedata, e.d);
                    check("wr_be", 32'(avm_byteenable), 32'(e.be));
                end
            end
            if (done) done_cnt++;
            if (wrapped) wrap_cnt++;
        end
        p_wr = avm_write; p_wait = avm_waitrequest;
        p_a = avm_address; p_d = avm_writedata; p_be = avm_byteenable;
    end

    // ---------------- sample source ----------------
    logic acc;
    always begin
        @(negedge clk);
        acc = smp_valid && smp_ready && reset_n;
        @(posedge clk); #1;
        if (acc && smp_q.size() > 0) void'(smp_q.pop_front());
        if (!reset_n || smp_q.size() == 0) smp_valid = 1'b0;
        else if (smp_valid && !acc) smp_valid = 1'b1;
        else smp_valid = !rand_valid || ($urandom_range(0, 3) != 0);
        smp_data = (smp_q.size() > 0) ? smp_q[0] : '0;
    end

    // ---------------- waitrequest source ----------------
    always begin
        @(posedge clk); #1;
        case (wr_mode)
            2: avm_waitrequest = ($urandom_range(0, 2) == 0);
            3: if (avm_write && stall_n < 3) begin avm_waitrequest = 1'b1; stall_n++; end
               else avm_waitrequest = 1'b0;
            4: avm_waitrequest = 1'b1;
            default: avm_waitrequest = 1'b0;
        endcase
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_start(input int base, input int len, input bit circ);
        cfg_base = AW'(base); cfg_len = (AW+1)'(len); cfg_circular = circ;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < 3000) begin tick(); k++; end
        if (k >= 3000) begin n_chk++; n_err++; $display("FAIL %s_timeout: no done within 3000 cycles", name); end
    endtask

    task automatic wait_q_empty(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 3000) begin tick(); k++; end
        if (k >= 3000) begin n_chk++; n_err++; $display("FAIL %s_timeout: %0d writes missing", name, exp_q.size()); end
    endtask

    task automatic wait_smp_empty(input string name);
        int k = 0;
        while ((smp_q.size() != 0 || smp_valid) && k < 3000) begin tick(); k++; end
        if (k >= 3000) begin n_chk++; n_err++; $display("FAIL %s_timeout: %0d samples not taken", name, smp_q.size()); end
    endtask

    function automatic logic [31:0] pack(input logic [SW-1:0] lo, input logic [SW-1:0] hi);
        return {16'(hi), 16'(lo)};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int d0, w0, k;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_base = '0; cfg_len = '0;
        cfg_circular = 1'b0; smp_valid = 1'b0; smp_data = '0; avm_waitrequest = 1'b0;
        tick(3);
        check("rst_busy", 32'(busy), 0);        check("rst_done", 32'(done), 0);
        check("rst_wrapped", 32'(wrapped), 0);  check("rst_write", 32'(avm_write), 0);
        check("rst_cs", 32'(avm_chipselect), 0); check("rst_ready", 32'(smp_ready), 0);
        check("rst_addr", 32'(avm_address), 0); check("rst_be", 32'(avm_byteenable), 0);
        check("rst_data", avm_writedata, 0);    check("rst_words", 32'(words_written), 0);
        reset_n = 1'b1; tick(2);

        // one-shot, no stall
        exp_q.push_back('{11'h010, 32'h00020001, 4'hF});
        exp_q.push_back('{11'h011, 32'h00040003, 4'hF});
        for (int i = 1; i <= 4; i++) smp_q.push_back(SW'(i));
        d0 = done_cnt;
        do_start(12'h010, 2, 1'b0);
        check("t1_busy", 32'(busy), 1);
        check("t1_ready_lo", 32'(smp_ready), 1);
        wait_done("t1");
        tick(2);
        check("t1_done_cnt", 32'(done_cnt - d0), 1);
        check("t1_words", 32'(words_written), 2);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_left", 32'(exp_q.size()), 0);

        // stall on the first write
        wr_mode = 3; stall_n = 0; max_run = 0; w0 = wr_cnt;
        exp_q.push_back('{11'h020, 32'h00060005, 4'hF});
        smp_q.push_back(12'h005); smp_q.push_back(12'h006);
        do_start(12'h020, 1, 1'b0);
        wait_done("t2");
        check("t2_stall_len", 32'(max_run), 4);
        check("t2_writes", 32'(wr_cnt - w0), 1);
        check("t2_words", 32'(words_written), 1);
        wr_mode = 0;

        // early stop flushes a half word
        exp_q.push_back('{11'h100, 32'h000B000A, 4'hF});
        exp_q.push_back('{11'h101, 32'h0000000C, 4'h3});
        smp_q.push_back(12'h00A); smp_q.push_back(12'h00B); smp_q.push_back(12'h00C);
        do_start(12'h100, 8, 1'b0);
        wait_smp_empty("t3");
        pulse_stop();
        wait_done("t3");
        check("t3_words", 32'(words_written), 2);
        check("t3_left", 32'(exp_q.size()), 0);

        // circular wrap at the top of memory
        d0 = wrap_cnt;
        exp_q.push_back('{11'h7FF, 32'h00020001, 4'hF});
        exp_q.push_back('{11'h000, 32'h00040003, 4'hF});
        exp_q.push_back('{11'h7FF, 32'h00060005, 4'hF});
        for (int i = 1; i <= 6; i++) smp_q.push_back(SW'(i));
        do_start(12'h7FF, 2, 1'b1);
        wait_q_empty("t4");
        tick(2);
        check("t4_wrapped", 32'(wrap_cnt - d0), 1);
        check("t4_busy", 32'(busy), 1);
        pulse_stop();
        wait_done("t4");
        check("t4_words", 32'(words_written), 1);

        // zero length
        w0 = wr_cnt;
        do_start(12'h123, 0, 1'b0);
        check("t5_done", 32'(done), 1);
        check("t5_nowrite", 32'(avm_write), 0);
        tick();
        check("t5_done_low", 32'(done), 0);
        check("t5_idle", 32'(busy), 0);
        tick(2);
        check("t5_writes", 32'(wr_cnt - w0), 0);

        // start while busy is ignored
        do_start(12'h200, 1, 1'b0);
        tick();
        do_start(12'h300, 3, 1'b1);
        exp_q.push_back('{11'h200, 32'h00220011, 4'hF});
        smp_q.push_back(12'h011); smp_q.push_back(12'h022);
        wait_done("t5b");
        check("t5b_words", 32'(words_written), 1);
        check("t5b_left", 32'(exp_q.size()), 0);

        // reset during a stalled write
        wr_mode = 4;
        smp_q.push_back(12'h007); smp_q.push_back(12'h008);
        do_start(12'h050, 2, 1'b0);
        k = 0;
        while (!avm_write && k < 100) begin tick(); k++; end
        check("t6_reached_write", 32'(avm_write), 1);
        d0 = done_cnt;
        reset_n = 1'b0; smp_q.delete();
        tick();
        check("t6_write", 32'(avm_write), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_addr", 32'(avm_address), 0);
        tick();
        reset_n = 1'b1; wr_mode = 0;
        tick(3);
        check("t6_no_done", 32'(done_cnt - d0), 0);
        exp_q.push_back('{11'h060, 32'h000A0009, 4'hF});
        smp_q.push_back(12'h009); smp_q.push_back(12'h00A);
        do_start(12'h060, 1, 1'b0);
        wait_done("t6b");
        check("t6b_left", 32'(exp_q.size()), 0);

        // randomized captures against the transaction-level model
        wr_mode = 2; rand_valid = 1'b1;
        for (int it = 0; it < 12; it++) begin
            int base, len, nw, wd0, dd0;
            bit circ;
            logic [SW-1:0] s0, s1;
            base = $urandom_range(0, 2047);
            len  = $urandom_range(1, 5);
            circ = 1'($urandom_range(0, 1));
            nw   = circ ? $urandom_range(1, 3 * len) : len;
            for (int w = 0; w < nw; w++) begin
                s0 = SW'($urandom); s1 = SW'($urandom);
                smp_q.push_back(s0); smp_q.push_back(s1);
                exp_q.push_back('{AW'((base + (w % len)) % 2048), pack(s0, s1), 4'hF});
            end
            wd0 = wrap_cnt; dd0 = done_cnt;
            do_start(base, len, circ);
            if (!circ) begin
                wait_done("rnd");
                check("rnd_words", 32'(words_written), 32'(len));
                check("rnd_wrap", 32'(wrap_cnt - wd0), 0);
            end else begin
                wait_q_empty("rnd_c");
                tick(2);
                check("rnd_c_wrap", 32'(wrap_cnt - wd0), 32'(nw / len));
                pulse_stop();
                wait_done("rnd_c");
                check("rnd_c_words", 32'(words_written), 32'(nw % len));
            end
            tick(2);
            check("rnd_done_cnt", 32'(done_cnt - dd0), 1);
            check("rnd_left", 32'(exp_q.size()), 0);
            check("rnd_smp_left", 32'(smp_q.size()), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adc_sample_avm_writer.md
Name: adc_sample_avm_writer

Overview:
- Avalon-MM write master: the initiator end of the on-chip memory slave port.
- Accepts 12-bit ADC samples on a valid/ready stream and packs two samples per 32-bit word.
- Writes words to consecutive word addresses of the on-chip sample memory, either as a one-shot capture or as a circular buffer.
- Sits between the ADC interface and the system on-chip memory in the Qsys system.

Parameters:
ADDR_W, 11, word-address width; matches a 2048-word memory.
SAMPLE_W, 12, ADC sample width; must be ≤ 16.

Ports:
clk  in  1  system clock; the only clock.
reset_n  in  1  synchronous, active-low reset.
start  in  1  one-cycle pulse; begins a capture when idle.
stop  in  1  level; ends the capture early, flushing any half-filled word.
cfg_base  in  ADDR_W  first word address; latched on start.
cfg_len  in  ADDR_W+1  number of words per pass (0..2^ADDR_W); latched on start.
cfg_circular  in  1  1 = restart at cfg_base after cfg_len words; latched on start.
smp_valid  in  1  sample available.
smp_data  in  SAMPLE_W  sample value.
smp_ready  out  1  writer accepts the sample this cycle.
avm_address  out  ADDR_W  word address.
avm_chipselect  out  1  equals avm_write.
avm_write  out  1  write request.
avm_byteenable  out  4  byte lanes.
avm_writedata  out  32  packed samples.
avm_waitrequest  in  1  slave stall; tie to 0 for the bare on-chip memory.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a capture ends.
wrapped  out  1  one-cycle pulse when the address returns to cfg_base in circular mode.
words_written  out  ADDR_W+1  words written in the current pass.

Behaviour:
- All registers and outputs are clocked on rising clk. The reset_n=0 sampled at an edge forces:
  - state IDLE; smp_ready, avm_write, avm_chipselect, busy, done, wrapped = 0.
  - avm_address = 0, avm_byteenable = 0, avm_writedata = 0, words_written = 0.
- Packing: each sample is zero-extended to 16 bits. The first sample of a word goes to [15:0], the second to [31:16].
- States: IDLE, LO, HI, WR, DONE.
- IDLE:
  - start=1 with cfg_len≠0: latch the config, address ← cfg_base, words_written ← 0, go to LO.
  - start=1 with cfg_len=0: go to DONE; no write is issued.
  - start is ignored in every other state.
- LO:
  - smp_ready=1. On smp_valid, store the low half and go to HI.
  - stop=1 (with or without a sample): no write is issued, go to DONE; a sample presented that cycle is not accepted.
- HI:
  - smp_ready=1. On smp_valid, store the high half, set byteenable=1111, go to WR.
  - stop=1 without a sample: upper half ← 0, byteenable=0011, go to WR, then DONE after the write.
  - stop=1 with smp_valid: the sample is accepted and a full word is written, then DONE.
- WR:
  - smp_ready=0. avm_write, avm_chipselect, avm_address, avm_writedata and avm_byteenable are all held stable while avm_waitrequest=1.
  - The write completes on the first edge where avm_write=1 and avm_waitrequest=0. At completion, words_written increments and avm_address increments modulo 2^ADDR_W.
  - Next state after completion:
    - Flush write, or stop seen during WR: DONE.
    - words_written reaches cfg_len with cfg_circular=0: DONE.
    - words_written reaches cfg_len with cfg_circular=1: address ← cfg_base, words_written ← 0, wrapped pulses, go to LO.
    - Otherwise: LO.
- DONE: done=1 for one cycle, then IDLE. busy falls in the same cycle that done is seen low again.
- Latency and throughput:
  - The sample accepted in HI at edge N produces avm_write=1 in cycle N+1.
  - With waitrequest=0 the block sustains 1 word per 3 cycles (LO, HI, WR); samples are never dropped, only back-pressured.
- Simultaneous events:
  - stop and write completion on the same edge: the write is counted, then DONE.
  - wrap and stop on the same edge: wrapped pulses and done pulses one cycle later.
- Reset mid-write: avm_write deasserts at that edge. The partial word is discarded and no done pulse is produced.

Test Plan:
- One-shot, waitrequest=0: cfg_base=0x010, cfg_len=2, samples 0x001..0x004 → writes 0x00020001@0x010 and 0x00040003@0x011, both be=1111; done pulses once; words_written=2.
- Stall: waitrequest held 1 for 3 cycles during the first write → address, data and byteenable stable for 4 cycles; exactly 1 write counted; smp_ready=0 throughout.
- Early stop: cfg_len=8; stop after 3 samples 0xA,0xB,0xC → writes 0x000B000A be=1111, then 0x0000000C be=0011; done; words_written=2.
- Circular wrap at the top of memory: cfg_base=0x7FF, cfg_len=2, circular=1, 6 samples → addresses 0x7FF, 0x000, 0x7FF; wrapped pulses after the second write; busy remains 1.
- Zero length and busy start: start with cfg_len=0 → done one cycle later, no avm_write. A second start during LO → ignored; the latched config is unchanged.
- Reset mid-operation: reset_n=0 during WR with waitrequest=1 → the next cycle shows avm_write=0, busy=0, address=0, and no done pulse; a subsequent start works normally.
